// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential signed divider:
//   div_state_e  - FSM state encoding (IDLE -> CALC -> FIXUP -> DONE)
//   DEFAULT_WIDTH - default divisor/quotient/remainder width
//   LATENCY       - start edge to DONE cycle, in cycles (2*WIDTH+2)
//   ZERO_DIV_Q    - quotient reported for a zero divisor (all ones)
// ----------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } div_state_e;

  localparam int DEFAULT_WIDTH = 32;
  localparam int LATENCY       = 2 * DEFAULT_WIDTH + 2;

  // All-ones pattern; the top replicates bit 0 out to its own WIDTH.
  localparam logic [DEFAULT_WIDTH-1:0] ZERO_DIV_Q = '1;

endpackage

// File: rtl/div_step.sv
// ----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step on unsigned magnitudes:
// shift the next dividend bit into the partial remainder, compare against
// the divisor, subtract when it fits and shift the new quotient bit in.
// Ports:
//   rem_in   [WIDTH:0]     partial remainder before the step
//   quo_in   [2*WIDTH-1:0] working quotient (unconsumed dividend bits on top)
//   divisor  [WIDTH-1:0]   divisor magnitude
//   rem_out  [WIDTH:0]     partial remainder after the step
//   quo_out  [2*WIDTH-1:0] working quotient after the step
// ----------------------------------------------------------------------------
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]     rem_in,
  input  logic [2*WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0]   divisor,
  output logic [WIDTH:0]     rem_out,
  output logic [2*WIDTH-1:0] quo_out
);

  logic [WIDTH+1:0] rem_shift;
  logic [WIDTH:0]   diff;
  logic             fits;

  always_comb begin
    rem_shift = {rem_in, quo_in[2*WIDTH-1]};
    fits      = (rem_shift >= {2'b00, divisor});
    // When the divisor fits, rem_shift < 2*divisor, so the difference
    // always lands in WIDTH+1 bits.
    diff      = rem_shift[WIDTH:0] - {1'b0, divisor};
    rem_out   = fits ? diff : rem_shift[WIDTH:0];
    quo_out   = {quo_in[2*WIDTH-2:0], fits};
  end

endmodule

// File: rtl/sequential_divider.sv
// ----------------------------------------------------------------------------
// sequential_divider
// Multi-cycle signed divider: 2*WIDTH-bit dividend by WIDTH-bit divisor.
// Quotient truncates toward zero, remainder takes the sign of the dividend.
// Optional overflow detection is built when SEQ_DIV_OVERFLOW_EN is defined;
// otherwise ovf is tied low and Q is the low WIDTH bits of the quotient.
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst      - synchronous active-high reset
//   en       - start request, sampled only in IDLE
//   A        - signed dividend, 2*WIDTH bits
//   B        - signed divisor, WIDTH bits
//   Q, R     - signed quotient / remainder
//   busy     - high in CALC and FIXUP
//   done     - one-cycle pulse when Q/R/div_zero/ovf are valid
//   div_zero - divisor was zero
//   ovf      - true quotient does not fit in signed WIDTH
//
// Handshake: a start is accepted on any rising edge where the FSM is IDLE,
// rst is low and en is high; A and B are captured on that edge only. done
// pulses for exactly one cycle, results hold until the next accepted start
// (which clears them), and en is ignored while busy or in DONE.
// ----------------------------------------------------------------------------
module sequential_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [2*WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]     B,
  output logic [WIDTH-1:0]     Q,
  output logic [WIDTH-1:0]     R,
  output logic                 busy,
  output logic                 done,
  output logic                 div_zero,
  output logic                 ovf
);

  localparam int CNT_W = $clog2(2 * WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(2 * WIDTH - 1);

  div_state_e state, state_next;

  logic [2*WIDTH-1:0] quo;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   mag_b;
  logic               neg_q;
  logic               neg_r;
  logic [CNT_W-1:0]   cnt;

  logic [2*WIDTH-1:0] abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               b_zero;
  logic               start;

  logic [2*WIDTH-1:0] step_quo;
  logic [WIDTH:0]     step_rem;

  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  // Magnitudes as unsigned values; the most-negative input negates to
  // itself, which is exactly its unsigned magnitude.
  always_comb begin
    abs_a  = A[2*WIDTH-1] ? -A : A;
    abs_b  = B[WIDTH-1] ? -B : B;
    b_zero = (B == '0);
    start  = (state == S_IDLE) && en;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .divisor (mag_b),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // Sign correction of the final magnitudes.
  always_comb begin
    r_fix = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end

`ifdef SEQ_DIV_OVERFLOW_EN
  logic [2*WIDTH-1:0] q_full;
  logic               ovf_next;
  logic               ovf_r;

  // The signed quotient fits in WIDTH bits only when its top WIDTH+1 bits
  // are all copies of the sign bit.
  always_comb begin
    q_full   = neg_q ? -quo : quo;
    q_fix    = q_full[WIDTH-1:0];
    ovf_next = ~(&q_full[2*WIDTH-1:WIDTH-1]) & (|q_full[2*WIDTH-1:WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (start) begin
      ovf_r <= 1'b0;
    end else if (state == S_FIXUP) begin
      ovf_r <= ovf_next;
    end
  end

  assign ovf = ovf_r;
`else
  // Low WIDTH bits of the negation only depend on the low WIDTH bits.
  always_comb begin
    q_fix = neg_q ? -quo[WIDTH-1:0] : quo[WIDTH-1:0];
  end

  assign ovf = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state and status outputs
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (en) begin
          // A zero divisor skips the iterations and reports on cycle 1.
          state_next = b_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (cnt == LAST_STEP) begin
          state_next = S_FIXUP;
        end
      end
      S_FIXUP: begin
        busy       = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      quo      <= '0;
      rem      <= '0;
      mag_b    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      cnt      <= '0;
      Q        <= '0;
      R        <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en) begin
            quo   <= abs_a;
            rem   <= '0;
            mag_b <= abs_b;
            neg_r <= A[2*WIDTH-1];
            neg_q <= A[2*WIDTH-1] ^ B[WIDTH-1];
            cnt   <= '0;
            if (b_zero) begin
              Q        <= {WIDTH{ZERO_DIV_Q[0]}};
              R        <= A[WIDTH-1:0];
              div_zero <= 1'b1;
            end else begin
              Q        <= '0;
              R        <= '0;
              div_zero <= 1'b0;
            end
          end
        end
        S_CALC: begin
          quo <= step_quo;
          rem <= step_rem;
          cnt <= cnt + CNT_W'(1);
        end
        S_FIXUP: begin
          Q <= q_fix;
          R <= r_fix;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_divider.sv
// ----------------------------------------------------------------------------
// tb_sequential_divider
// Directed bench for sequential_divider at WIDTH=32. Cycle k of a division
// is the clock period ending at the k-th rising edge after the start edge;
// outputs are observed on the falling edge inside that period.
// ----------------------------------------------------------------------------
module tb_sequential_divider;

  localparam int W   = 32;
  localparam int LAT = 66;

`ifdef SEQ_DIV_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic           en;
  logic [2*W-1:0] A;
  logic [W-1:0]   B;
  logic [W-1:0]   Q;
  logic [W-1:0]   R;
  logic           busy;
  logic           done;
  logic           div_zero;
  logic           ovf;

  int compared   = 0;
  int mismatched = 0;

  sequential_divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .A        (A),
    .B        (B),
    .Q        (Q),
    .R        (R),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .ovf      (ovf)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start one division from the current falling edge and follow it to
  // completion. poke >= 1 pulses en with a zero divisor at that cycle;
  // hold keeps en high throughout.
  task automatic do_div(input string tag, input logic [63:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er,
                        input logic edz, input logic eovf, input int lat,
                        input int poke, input bit hold);
    A  = a;
    B  = b;
    en = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) en = 1'b0;
    A = {$urandom, $urandom};
    B = $urandom;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      check({tag, " busy/done"}, {62'd0, busy, done},
            {62'd0, (k < lat), (k == lat)});
      if (k == poke) begin
        en = 1'b1;
        B  = '0;
      end else if (k == poke + 1 && !hold) begin
        en = 1'b0;
      end
    end
    check({tag, " Q"}, {32'd0, Q}, {32'd0, eq});
    check({tag, " R"}, {32'd0, R}, {32'd0, er});
    check({tag, " div_zero"}, {63'd0, div_zero}, {63'd0, edz});
    check({tag, " ovf"}, {63'd0, ovf}, {63'd0, eovf});
    @(negedge clk);
    check({tag, " done low after"}, {63'd0, done}, 64'd0);
    check({tag, " Q held"}, {32'd0, Q}, {32'd0, eq});
  endtask

  // Scoreboard reference for random pairs: signed 64-bit division.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_r[$];
  logic         exp_o[$];

  initial begin
    longint       ra, rb, rq, rr;
    logic [63:0]  rq_bits;
    logic [63:0]  ra_bits;
    logic [31:0]  eq, er;
    logic         eo;

    rst = 1'b1;
    en  = 1'b1;
    A   = '0;
    B   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset Q", {32'd0, Q}, 64'd0);
    check("reset R", {32'd0, R}, 64'd0);
    check("reset flags", {60'd0, busy, done, div_zero, ovf}, 64'd0);
    rst = 1'b0;
    en  = 1'b0;
    @(negedge clk);
    check("idle busy", {63'd0, busy}, 64'd0);

    // Directed vectors
    do_div("1500/-60", 64'd1500, -32'sd60, -32'sd25, 32'd0, 1'b0, 1'b0, LAT, 0, 1'b0);
    do_div("-51/4", -64'sd51, 32'd4, -32'sd12, -32'sd3, 1'b0, 1'b0, LAT, 0, 1'b0);
    do_div("51/-4", 64'd51, -32'sd4, -32'sd12, 32'd3, 1'b0, 1'b0, LAT, 0, 1'b0);
    do_div("1234/0", 64'd1234, 32'd0, 32'hFFFFFFFF, 32'd1234, 1'b1, 1'b0, 1, 0, 1'b0);
    do_div("2^40/3", 64'h0000_0100_0000_0000, 32'd3, 32'h55555555, 32'd1,
           1'b0, OVF_EN, LAT, 0, 1'b0);
    do_div("-2^31/1", 64'hFFFF_FFFF_8000_0000, 32'd1, 32'h80000000, 32'd0,
           1'b0, 1'b0, LAT, 0, 1'b0);
    do_div("2^31/1", 64'h0000_0000_8000_0000, 32'd1, 32'h80000000, 32'd0,
           1'b0, OVF_EN, LAT, 0, 1'b0);
    do_div("-2^63/1", 64'h8000_0000_0000_0000, 32'd1, 32'h00000000, 32'd0,
           1'b0, OVF_EN, LAT, 0, 1'b0);
    do_div("-2^31/-2^31", 64'hFFFF_FFFF_8000_0000, 32'h80000000, 32'd1, 32'd0,
           1'b0, 1'b0, LAT, 0, 1'b0);

    // en pulsed mid-division (with a zero divisor) must be ignored
    do_div("en poke", 64'd1000, 32'd7, 32'd142, 32'd6, 1'b0, 1'b0, LAT, 10, 1'b0);

    // Reset in the middle of CALC, en held high across the reset
    A  = 64'd5000;
    B  = 32'd9;
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
    end
    check("pre-rst busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    en  = 1'b1;
    @(negedge clk);
    check("mid rst Q", {32'd0, Q}, 64'd0);
    check("mid rst R", {32'd0, R}, 64'd0);
    check("mid rst flags", {60'd0, busy, done, div_zero, ovf}, 64'd0);
    rst = 1'b0;
    en  = 1'b0;
    do_div("after rst", -64'sd1000, 32'd3, -32'sd333, -32'sd1, 1'b0, 1'b0, LAT, 0, 1'b0);

    // Back-to-back random pairs with en held high
    for (int i = 0; i < 8; i++) begin
      ra = longint'($signed($urandom)) * longint'($urandom_range(1, 4000));
      rb = longint'($urandom_range(1, 200000));
      if ($urandom_range(0, 1) == 1) rb = -rb;
      if (i == 0) rb = -rb;
      rq = ra / rb;
      rr = ra % rb;
      rq_bits = rq;
      exp_q.push_back(rq_bits[31:0]);
      rq_bits = rr;
      exp_r.push_back(rq_bits[31:0]);
      exp_o.push_back(OVF_EN && (rq > 64'sd2147483647 || rq < -64'sd2147483648));
      ra_bits = ra;
      rq_bits = rb;
      eq = exp_q.pop_front();
      er = exp_r.pop_front();
      eo = exp_o.pop_front();
      do_div($sformatf("b2b%0d", i), ra_bits, rq_bits[31:0], eq, er, 1'b0, eo, LAT, 0, 1'b1);
    end
    // The final IDLE cycle had en high, so another division must have begun.
    @(negedge clk);
    check("b2b restart busy", {63'd0, busy}, 64'd1);
    en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sequential_divider.md
SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning divisor/quotient/remainder width; dividend is 2*WIDTH.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port en  in  1  start request, sampled only in IDLE.
REQ-005 SHALL have port A  in  2*WIDTH  signed dividend.
REQ-006 SHALL have port B  in  WIDTH  signed divisor.
REQ-007 SHALL have port Q  out  WIDTH  signed quotient, truncated toward zero.
REQ-008 SHALL have port R  out  WIDTH  signed remainder, sign of dividend.
REQ-009 SHALL have port busy  out  1  high while a division is in progress.
REQ-010 SHALL have port done  out  1  one-cycle pulse when Q/R/flags become valid.
REQ-011 SHALL have port div_zero  out  1  divisor was zero.
REQ-012 SHALL have port ovf  out  1  true quotient does not fit in signed WIDTH.

Function
REQ-013 SHALL implement FSM IDLE -> CALC -> FIXUP -> DONE -> IDLE.
REQ-014 The edge sampling en=1 in IDLE is cycle 0. At that edge the block SHALL latch |A|, |B|, sign(A), and sign(A)^sign(B).
REQ-015 If B==0 at cycle 0, the FSM SHALL go directly to DONE. At cycle 1: done=1, div_zero=1, Q=all-ones, R=A[WIDTH-1:0], ovf=0.
REQ-016 CALC SHALL run exactly 2*WIDTH restoring steps, one per cycle, on the magnitudes (cycles 1..2*WIDTH).
  - Working quotient: 2*WIDTH bits.
  - Partial remainder: WIDTH+1 bits.
REQ-017 FIXUP (cycle 2*WIDTH+1) SHALL:
  - negate the quotient if the signs differ;
  - negate the remainder if A<0;
  - compute ovf.
REQ-018 DONE (cycle 2*WIDTH+2) SHALL assert done for exactly one cycle with Q, R, div_zero and ovf valid, then return to IDLE.
REQ-019 busy SHALL be 1 in CALC and FIXUP, and 0 in IDLE and DONE.
REQ-020 en SHALL be ignored outside IDLE. en held high SHALL start a new division on the cycle after DONE.
REQ-021 Q, R, div_zero and ovf SHALL hold their values from DONE until the next accepted start. They SHALL then be cleared to 0 on that start edge.
REQ-022 A and B MAY change after cycle 0 without affecting the result.
REQ-023 Signed edge cases:
  - The most-negative A (-2^(2W-1)) SHALL be handled via its unsigned magnitude.
  - A quotient of exactly -2^(WIDTH-1) SHALL NOT flag ovf.
  - A quotient of +2^(WIDTH-1) SHALL flag ovf.
REQ-024 On ovf, Q SHALL be the low WIDTH bits of the signed quotient and R SHALL be exact.

Reset
REQ-025 rst=1 at any edge SHALL force state IDLE and Q=0, R=0, busy=0, done=0, div_zero=0, ovf=0, including mid-CALC. No partial result SHALL be output.
REQ-026 en SHALL be ignored in any cycle where rst=1.

Configuration
REQ-027 Macro SEQ_DIV_OVERFLOW_EN:
  - Defined: overflow detection per REQ-017/023/024.
  - Undefined: ovf tied to 0, overflow logic absent, Q = low WIDTH bits.
  - Latency SHALL be identical in both cases.

Structure
REQ-028 Package div_pkg SHALL hold:
  - the state enum typedef;
  - the default WIDTH;
  - the LATENCY constant (2*WIDTH+2);
  - the zero-divisor Q value.
REQ-029 The single restoring step (compare/subtract/shift) SHALL be a combinational sub-module div_step, instantiated once in CALC.

Verification (WIDTH=32)
REQ-030 A=1500, B=-60 -> done at cycle 66 with Q=-25, R=0, ovf=0, div_zero=0; busy high cycles 1..65.
REQ-031 A=-51, B=4 -> Q=-12, R=-3. A=51, B=-4 -> Q=-12, R=3.
REQ-032 A=1234, B=0 -> done at cycle 1 with div_zero=1, Q=32'hFFFFFFFF, R=1234.
REQ-033 Overflow cases (macro defined):
  - A=2^40, B=3 -> ovf=1, R=1.
  - A=-2^31, B=1 -> ovf=0, Q=-2^31.
  - A=2^31, B=1 -> ovf=1.
REQ-034 Handshake and reset:
  - en pulsed at cycle 10 of a running division -> ignored; result unchanged.
  - rst at cycle 20 -> all outputs 0 next cycle, FSM in IDLE.
  - A new start after that reset -> correct result.
REQ-035 Back-to-back with en held high -> second division accepted on the cycle after done. The bench SHALL check 8 random signed pairs against a reference model.
